// File: rtl/tug_pkg.sv
// -----------------------------------------------------------------------------
// tug_pkg
// Shared types and constants for the tug-of-war round referee.
//   winner_t    : round winner encoding driven on the `winner` output
//   ref_state_t : referee FSM states
//   SEG_BLANK   : active-low 7-segment code with every segment dark
//   SEG_ZERO    : active-low 7-segment code for the digit '0'
// -----------------------------------------------------------------------------
package tug_pkg;

  typedef enum logic [1:0] {
    WIN_NONE  = 2'b00,
    WIN_RIGHT = 2'b01,
    WIN_LEFT  = 2'b10
  } winner_t;

  typedef enum logic [1:0] {
    PLAY,
    HOLD,
    RESTART,
    OVER
  } ref_state_t;

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_ZERO  = 7'b1000000;

endpackage : tug_pkg

// File: rtl/seg7_digit.sv
// -----------------------------------------------------------------------------
// seg7_digit
// Combinational decoder: 4-bit value to active-low 7-segment pattern.
// Bit order is {g,f,e,d,c,b,a}. Values 0-9 show the digit; 10-15 are blank.
//   value_i : digit value to display
//   seg_o   : active-low segment drive
// -----------------------------------------------------------------------------
module seg7_digit
  import tug_pkg::*;
(
  input  logic [3:0] value_i,
  output logic [6:0] seg_o
);

  always_comb begin
    seg_o = SEG_BLANK;
    case (value_i)
      4'd0: seg_o = 7'b1000000;
      4'd1: seg_o = 7'b1111001;
      4'd2: seg_o = 7'b0100100;
      4'd3: seg_o = 7'b0110000;
      4'd4: seg_o = 7'b0011001;
      4'd5: seg_o = 7'b0010010;
      4'd6: seg_o = 7'b0000010;
      4'd7: seg_o = 7'b1111000;
      4'd8: seg_o = 7'b0000000;
      4'd9: seg_o = 7'b0010000;
      default: seg_o = SEG_BLANK;
    endcase
  end

endmodule : seg7_digit

// File: rtl/tug_round_referee.sv
// -----------------------------------------------------------------------------
// tug_round_referee
// Downstream referee of the tug-of-war light chain. Detects a round win from
// the edge lights and the conditioned presses, keeps per-player scores, holds
// the winner on display for HOLD_CYCLES cycles, then pulses restartGame for
// one cycle to clear the playfield. The match ends (OVER) when a score
// reaches SCORE_MAX; only Reset leaves OVER.
//
// Optional build macro: TUG_REFEREE_HEX_EN adds active-low 7-segment score
// digits hexLeft / hexRight, registered together with the scores.
//
// Ports:
//   Clock        : system clock, posedge
//   Reset        : asynchronous active-high reset
//   L, R         : single-cycle player presses
//   leftEdgeOn   : lightOn of leftmost playfield light
//   rightEdgeOn  : lightOn of rightmost playfield light
//   restartGame  : one-cycle field-clear pulse
//   winner       : WIN_NONE / WIN_LEFT / WIN_RIGHT of current/last round
//   leftScore    : left player rounds won
//   rightScore   : right player rounds won
//   gameOver     : high once a score reaches SCORE_MAX
//   hexLeft      : (TUG_REFEREE_HEX_EN) 7-seg digit of leftScore
//   hexRight     : (TUG_REFEREE_HEX_EN) 7-seg digit of rightScore
// -----------------------------------------------------------------------------
module tug_round_referee
  import tug_pkg::*;
#(
  parameter int SCORE_W     = 3,
  parameter int SCORE_MAX   = 7,
  parameter int HOLD_CYCLES = 4
) (
  input  logic               Clock,
  input  logic               Reset,
  input  logic               L,
  input  logic               R,
  input  logic               leftEdgeOn,
  input  logic               rightEdgeOn,
  output logic               restartGame,
  output logic [1:0]         winner,
  output logic [SCORE_W-1:0] leftScore,
  output logic [SCORE_W-1:0] rightScore,
  output logic               gameOver
`ifdef TUG_REFEREE_HEX_EN
  ,
  output logic [6:0]         hexLeft,
  output logic [6:0]         hexRight
`endif
);

  // Hold counter only needs to reach HOLD_CYCLES-1.
  localparam int                 CNT_W       = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [CNT_W-1:0]   HOLD_LOAD   = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [SCORE_W-1:0] SCORE_MAX_V = SCORE_W'(SCORE_MAX);

  ref_state_t         state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  winner_t            win_q, win_d;
  logic [SCORE_W-1:0] ls_q, ls_d;
  logic [SCORE_W-1:0] rs_q, rs_d;
  logic               restart_q, restart_d;
  logic               over_q, over_d;

  logic               left_win;
  logic               right_win;
  logic [SCORE_W-1:0] win_score;

  // A press only counts when the matching edge is lit and the opponent is
  // not pressing in the same cycle; simultaneous presses cancel out.
  assign left_win  = leftEdgeOn  & L & ~R;
  assign right_win = rightEdgeOn & R & ~L;

  // Score of whoever won the round being held.
  assign win_score = (win_q == WIN_LEFT) ? ls_q : rs_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    win_d   = win_q;
    ls_d    = ls_q;
    rs_d    = rs_q;

    case (state_q)
      PLAY: begin
        if (left_win && !right_win) begin
          ls_d    = (ls_q == SCORE_MAX_V) ? ls_q : ls_q + 1'b1;
          win_d   = WIN_LEFT;
          cnt_d   = HOLD_LOAD;
          state_d = HOLD;
        end else if (right_win && !left_win) begin
          rs_d    = (rs_q == SCORE_MAX_V) ? rs_q : rs_q + 1'b1;
          win_d   = WIN_RIGHT;
          cnt_d   = HOLD_LOAD;
          state_d = HOLD;
        end
      end

      HOLD: begin
        // Loaded with HOLD_CYCLES-1 on entry, so the exit decision at zero
        // makes HOLD last exactly HOLD_CYCLES cycles.
        if (cnt_q == '0) begin
          state_d = (win_score == SCORE_MAX_V) ? OVER : RESTART;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end

      RESTART: begin
        win_d   = WIN_NONE;
        state_d = PLAY;
      end

      OVER: begin
        state_d = OVER;
      end

      default: begin
        state_d = PLAY;
      end
    endcase
  end

  // Outputs are registered copies decoded from the next state so they line up
  // with the state they describe.
  assign restart_d = (state_d == RESTART);
  assign over_d    = (state_d == OVER);

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_q   <= PLAY;
      cnt_q     <= '0;
      win_q     <= WIN_NONE;
      ls_q      <= '0;
      rs_q      <= '0;
      restart_q <= 1'b0;
      over_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      win_q     <= win_d;
      ls_q      <= ls_d;
      rs_q      <= rs_d;
      restart_q <= restart_d;
      over_q    <= over_d;
    end
  end

  assign restartGame = restart_q;
  assign winner      = win_q;
  assign leftScore   = ls_q;
  assign rightScore  = rs_q;
  assign gameOver    = over_q;

`ifdef TUG_REFEREE_HEX_EN
  logic [3:0] hex_left_val;
  logic [3:0] hex_right_val;
  logic [6:0] hex_left_d, hex_left_q;
  logic [6:0] hex_right_d, hex_right_q;

  // Scores above 9 map to 15 so the decoder blanks them regardless of width.
  assign hex_left_val  = (32'(ls_d) > 32'd9) ? 4'hF : 4'(ls_d);
  assign hex_right_val = (32'(rs_d) > 32'd9) ? 4'hF : 4'(rs_d);

  seg7_digit u_seg_left (
    .value_i (hex_left_val),
    .seg_o   (hex_left_d)
  );

  seg7_digit u_seg_right (
    .value_i (hex_right_val),
    .seg_o   (hex_right_d)
  );

  // Decoded from the next-state scores so the digits change on the same
  // edge as the score registers.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      hex_left_q  <= SEG_ZERO;
      hex_right_q <= SEG_ZERO;
    end else begin
      hex_left_q  <= hex_left_d;
      hex_right_q <= hex_right_d;
    end
  end

  assign hexLeft  = hex_left_q;
  assign hexRight = hex_right_q;
`endif

endmodule : tug_round_referee

// File: doc/tug_round_referee.md
Name: tug_round_referee

Overview:
Downstream stage of the tug-of-war light chain. Watches the two edge playfield lights and the conditioned player presses, detects a round win, keeps per-player scores, and generates the `restartGame` pulse that every light cell consumes to clear the field. Declares the match over when a player reaches `SCORE_MAX`.

Parameters:
- SCORE_W, 3, width of each score counter
- SCORE_MAX, 7, score that ends the match; must be ≤ 2^SCORE_W-1
- HOLD_CYCLES, 4, cycles the winner is held/displayed before restart; ≥1

Ports:
- Clock  in  1  system clock; all state updates on posedge
- Reset  in  1  asynchronous, active-high; clears all state
- L  in  1  left player press, single-cycle pulse (already conditioned)
- R  in  1  right player press, single-cycle pulse
- leftEdgeOn  in  1  `lightOn` of leftmost playfield light
- rightEdgeOn  in  1  `lightOn` of rightmost playfield light
- restartGame  out  1  one-cycle pulse; clears all playfield lights
- winner  out  2  `WIN_NONE` / `WIN_LEFT` / `WIN_RIGHT` of current/last round
- leftScore  out  SCORE_W  left player rounds won
- rightScore  out  SCORE_W  right player rounds won
- gameOver  out  1  high once either score reaches `SCORE_MAX`

Behaviour:
- Reset (async, any state, mid-hold included) puts the block in the following condition:
  - state=PLAY, both scores 0, `winner`=`WIN_NONE`, `restartGame`=0, `gameOver`=0, hold counter 0.
- Win events (combinational, evaluated in PLAY only):
  - leftWin = `leftEdgeOn` & `L` & ~`R`
  - rightWin = `rightEdgeOn` & `R` & ~`L`
  - leftWin & rightWin together (both edges lit, illegal field) -> no win; stay PLAY.
- FSM states are PLAY, HOLD, RESTART, OVER. All outputs are registered, Moore style.
- PLAY:
  - On leftWin, at the next edge: `leftScore`+1, `winner`=`WIN_LEFT`, hold counter=HOLD_CYCLES-1, go to HOLD. The 1-cycle latency from press to score/winner is required.
  - rightWin is symmetric.
  - Otherwise stay in PLAY.
- HOLD:
  - All L/R/edge inputs are ignored.
  - Counter decrements each cycle.
  - When the counter is 0: go to OVER if the winner's score == `SCORE_MAX`, else go to RESTART.
  - Result: HOLD lasts exactly HOLD_CYCLES cycles.
- RESTART:
  - `restartGame`=1 for exactly this one cycle.
  - `winner`=`WIN_NONE` on exit.
  - Next state is PLAY.
  - Presses during RESTART are ignored. The field is being cleared synchronously by the light cells in this same cycle.
- OVER:
  - `gameOver`=1, `winner` held, scores frozen, `restartGame`=0, all inputs ignored.
  - Leaves only via Reset.
- Score arithmetic: saturating at `SCORE_MAX`; never wraps. This is unreachable by construction because OVER is entered first.
- Scores persist across rounds. Only Reset clears them.

Optional Feature:
Macro `TUG_REFEREE_HEX_EN`.
- Defined: adds outputs `hexLeft` [6:0] and `hexRight` [6:0], active-low 7-segment digits of `leftScore` and `rightScore` (0-9; codes above 9 blank = 7'h7F). Both are registered with the scores; reset value is the code for '0' (7'b1000000).
- Undefined: these ports and their logic do not exist. All other behaviour is identical.

Decomposition:
Package `tug_pkg` holds:
- typedef enum logic [1:0] `winner_t` {`WIN_NONE`=2'b00, `WIN_RIGHT`=2'b01, `WIN_LEFT`=2'b10}
- typedef enum logic [1:0] `ref_state_t` {PLAY, HOLD, RESTART, OVER}
- constant `SEG_BLANK`=7'h7F

Sub-module `seg7_digit` (4-bit value -> active-low 7 segments, combinational) is instantiated twice, only under `TUG_REFEREE_HEX_EN`. Score counters stay inline.

Test Plan (SCORE_MAX=2, HOLD_CYCLES=4):
1. Reset asserted mid-cycle with no clock edge -> all outputs clear immediately. Scores 0, `winner`=00, `gameOver`=0.
2. `leftEdgeOn`=1, L pulse 1 cycle -> next cycle `leftScore`=1, `winner`=10. `restartGame` rises exactly 4 cycles later for 1 cycle, then `winner`=00 and state returns to PLAY.
3. `leftEdgeOn`=1, L=R=1 together; then `rightEdgeOn`=0, R=1 -> no score change, `restartGame` never pulses.
4. Right wins twice (with presses injected during HOLD and RESTART) -> stray presses produce no extra score. After the 2nd win plus 4 cycles: `rightScore`=2, `gameOver`=1, `winner`=01, `restartGame` stays 0. Further L/R pulses change nothing.
5. Reset asserted during HOLD after a left win -> immediate PLAY, scores 0, no `restartGame` pulse follows.
6. (`TUG_REFEREE_HEX_EN`) `leftScore` 0->1 -> `hexLeft` 7'b1000000 -> 7'b1111001 on the same edge as the score update.
